// File: rtl/root_pifo_dequeue_scheduler_pkg.sv
// Shared definitions for the root PIFO dequeue scheduler.
// Contents: descriptor field positions, rank/address/stat widths, pop latency,
// starvation limit (only when ROOT_SCHED_STARVE_GUARD_EN is defined), and FSM state codes.
package root_pifo_dequeue_scheduler_pkg;

    localparam int unsigned BUFFER_ADDR_WIDTH        = 12;
    localparam int unsigned PIFO_RANK_WIDTH          = 19;
    localparam int unsigned PIFO_ROOT_WIDTH          = 32;
    localparam int unsigned ROOT_RANK_START_POS      = 12;
    localparam int unsigned ROOT_RANK_END_POS        = 30;
    localparam int unsigned ROOT_PIFO_INFO_VALID_POS = 31;
    localparam int unsigned STAT_WIDTH               = 32;

    // Cycles after a pop before the calendar top reflects the new head (>= 1).
    localparam int unsigned POP_LATENCY = 2;
    localparam int unsigned WAIT_WIDTH  = $clog2(POP_LATENCY + 1);

`ifdef ROOT_SCHED_STARVE_GUARD_EN
    // Consecutive bypasses over a valid calendar top before a pop is forced.
    localparam int unsigned STARVE_LIMIT = 8;
    localparam int unsigned STARVE_WIDTH = $clog2(STARVE_LIMIT + 1);
`endif

    localparam logic [0:0] ST_IDLE     = 1'b0;
    localparam logic [0:0] ST_POP_WAIT = 1'b1;

endpackage

// File: rtl/root_pifo_dequeue_scheduler_rank_compare.sv
// root_rank_compare: extracts valid/rank from the arrival and calendar-top
// descriptors and decides whether the arrival may bypass the calendar.
// Ports:
//   arrival_meta  - arrival descriptor bits [valid:rank LSB]
//   top_meta      - calendar top descriptor bits [valid:rank LSB]
//   arrival_valid - arrival valid bit
//   top_valid     - calendar top valid bit
//   bypass_ok     - arrival valid and (no top, or strictly lower rank)
module root_rank_compare
    import root_pifo_dequeue_scheduler_pkg::*;
(
    input  logic [ROOT_PIFO_INFO_VALID_POS:ROOT_RANK_START_POS] arrival_meta,
    input  logic [ROOT_PIFO_INFO_VALID_POS:ROOT_RANK_START_POS] top_meta,
    output logic                                                arrival_valid,
    output logic                                                top_valid,
    output logic                                                bypass_ok
);

    logic [PIFO_RANK_WIDTH-1:0] arrival_rank;
    logic [PIFO_RANK_WIDTH-1:0] top_rank;

    assign arrival_valid = arrival_meta[ROOT_PIFO_INFO_VALID_POS];
    assign top_valid     = top_meta[ROOT_PIFO_INFO_VALID_POS];
    assign arrival_rank  = arrival_meta[ROOT_RANK_END_POS:ROOT_RANK_START_POS];
    assign top_rank      = top_meta[ROOT_RANK_END_POS:ROOT_RANK_START_POS];

    // Equal ranks go to the calendar so earlier-inserted work keeps its order.
    assign bypass_ok = arrival_valid & (~top_valid | (arrival_rank < top_rank));

endmodule

// File: rtl/root_pifo_dequeue_scheduler.sv
// root_pifo_dequeue_scheduler: per-cycle choice between bypassing an arriving
// root descriptor to the output register, inserting it into the calendar PIFO,
// and popping the calendar top into the output register.
// Optional feature macro: ROOT_SCHED_STARVE_GUARD_EN (forces a calendar pop after
// a run of bypasses while the calendar holds work).
// Ports:
//   clk, rstn                 - clock, synchronous active-low reset
//   s_axis_pifo_info(_ready)  - arriving descriptor / accepted this cycle
//   s_axis_pifo_calandar_top  - calendar top descriptor
//   s_calendar_full           - calendar cannot take an insert
//   m_calendar_insert_en/data - insert strobe and descriptor
//   m_calendar_pop_en         - pop strobe
//   m_axis_out_data/valid     - registered output descriptor
//   m_axis_out_ready          - downstream accept
//   stat_bypass_cnt/pop_cnt   - wrapping event counters
module root_pifo_dequeue_scheduler
    import root_pifo_dequeue_scheduler_pkg::*;
(
    input  logic                       clk,
    input  logic                       rstn,
    input  logic [PIFO_ROOT_WIDTH-1:0] s_axis_pifo_info,
    output logic                       s_axis_pifo_info_ready,
    input  logic [PIFO_ROOT_WIDTH-1:0] s_axis_pifo_calandar_top,
    input  logic                       s_calendar_full,
    output logic                       m_calendar_insert_en,
    output logic [PIFO_ROOT_WIDTH-1:0] m_calendar_insert_data,
    output logic                       m_calendar_pop_en,
    output logic [PIFO_ROOT_WIDTH-1:0] m_axis_out_data,
    output logic                       m_axis_out_valid,
    input  logic                       m_axis_out_ready,
    output logic [STAT_WIDTH-1:0]      stat_bypass_cnt,
    output logic [STAT_WIDTH-1:0]      stat_pop_cnt
);

    logic                  arrival_valid;
    logic                  top_valid;
    logic                  bypass_ok;
    logic                  force_pop;
    logic                  slot_free;

    logic [0:0]            state_q, state_d;
    logic [WAIT_WIDTH-1:0] wait_q, wait_d;
    logic                  do_bypass, do_pop, do_insert;

    root_rank_compare u_rank_compare (
        .arrival_meta  (s_axis_pifo_info[ROOT_PIFO_INFO_VALID_POS:ROOT_RANK_START_POS]),
        .top_meta      (s_axis_pifo_calandar_top[ROOT_PIFO_INFO_VALID_POS:ROOT_RANK_START_POS]),
        .arrival_valid (arrival_valid),
        .top_valid     (top_valid),
        .bypass_ok     (bypass_ok)
    );

    assign slot_free = ~m_axis_out_valid | m_axis_out_ready;

`ifdef ROOT_SCHED_STARVE_GUARD_EN
    logic [STARVE_WIDTH-1:0] starve_q;

    assign force_pop = top_valid & (starve_q >= STARVE_WIDTH'(STARVE_LIMIT));

    // Counts bypasses that overtook a waiting calendar top; saturates at the limit.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            starve_q <= '0;
        end else if (do_pop || !top_valid) begin
            starve_q <= '0;
        end else if (do_bypass && (starve_q < STARVE_WIDTH'(STARVE_LIMIT))) begin
            starve_q <= starve_q + STARVE_WIDTH'(1);
        end
    end
`else
    assign force_pop = 1'b0;
`endif

    // Next-state and strobe decode; all strobes are held low during reset.
    always_comb begin
        state_d   = state_q;
        wait_d    = wait_q;
        do_bypass = 1'b0;
        do_pop    = 1'b0;
        do_insert = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (slot_free && bypass_ok && !force_pop) begin
                    do_bypass = 1'b1;
                end else if (slot_free && top_valid) begin
                    do_pop    = 1'b1;
                    do_insert = arrival_valid & ~s_calendar_full;
                    state_d   = ST_POP_WAIT;
                    wait_d    = WAIT_WIDTH'(POP_LATENCY);
                end else begin
                    do_insert = arrival_valid & ~s_calendar_full;
                end
            end
            ST_POP_WAIT: begin
                // Calendar top is stale here: never bypass or pop against it.
                do_insert = arrival_valid & ~s_calendar_full;
                if (wait_q <= WAIT_WIDTH'(1)) begin
                    state_d = ST_IDLE;
                    wait_d  = '0;
                end else begin
                    wait_d  = wait_q - WAIT_WIDTH'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                wait_d  = '0;
            end
        endcase
        if (!rstn) begin
            do_bypass = 1'b0;
            do_pop    = 1'b0;
            do_insert = 1'b0;
        end
    end

    assign s_axis_pifo_info_ready = do_bypass | do_insert;
    assign m_calendar_insert_en   = do_insert;
    assign m_calendar_insert_data = rstn ? s_axis_pifo_info : '0;
    assign m_calendar_pop_en      = do_pop;

    // State, output register and statistics.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q          <= ST_IDLE;
            wait_q           <= '0;
            m_axis_out_valid <= 1'b0;
            m_axis_out_data  <= '0;
            stat_bypass_cnt  <= '0;
            stat_pop_cnt     <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            if (do_bypass) begin
                m_axis_out_valid <= 1'b1;
                m_axis_out_data  <= s_axis_pifo_info;
            end else if (do_pop) begin
                m_axis_out_valid <= 1'b1;
                m_axis_out_data  <= s_axis_pifo_calandar_top;
            end else if (m_axis_out_ready) begin
                m_axis_out_valid <= 1'b0;
            end
            if (do_bypass) stat_bypass_cnt <= stat_bypass_cnt + STAT_WIDTH'(1);
            if (do_pop)    stat_pop_cnt    <= stat_pop_cnt + STAT_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_root_pifo_dequeue_scheduler.sv
// Directed self-checking bench for root_pifo_dequeue_scheduler.
// Honours ROOT_SCHED_STARVE_GUARD_EN for the starvation scenario.
module tb_root_pifo_dequeue_scheduler;

    logic        clk = 1'b0;
    logic        rstn;
    logic [31:0] info;
    logic        info_ready;
    logic [31:0] top;
    logic        cal_full;
    logic        ins_en;
    logic [31:0] ins_data;
    logic        pop_en;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] bypass_cnt;
    logic [31:0] pop_cnt;

    int tests  = 0;
    int errors = 0;

    always #5 clk = ~clk;

    root_pifo_dequeue_scheduler dut (
        .clk                      (clk),
        .rstn                     (rstn),
        .s_axis_pifo_info         (info),
        .s_axis_pifo_info_ready   (info_ready),
        .s_axis_pifo_calandar_top (top),
        .s_calendar_full          (cal_full),
        .m_calendar_insert_en     (ins_en),
        .m_calendar_insert_data   (ins_data),
        .m_calendar_pop_en        (pop_en),
        .m_axis_out_data          (out_data),
        .m_axis_out_valid         (out_valid),
        .m_axis_out_ready         (out_ready),
        .stat_bypass_cnt          (bypass_cnt),
        .stat_pop_cnt             (pop_cnt)
    );

    function automatic logic [31:0] mk(input logic v, input logic [18:0] r, input logic [11:0] a);
        return {v, r, a};
    endfunction

    task automatic test_reset();
        rstn = 1'b0; info = mk(1'b1, 19'd5, 12'h1); top = mk(1'b1, 19'd3, 12'h2);
        cal_full = 1'b0; out_ready = 1'b1;
        @(negedge clk); #1;
        tests++;
        if ({info_ready, ins_en, pop_en} !== 3'b000 || ins_data !== 32'h0) begin
            errors++; $display("FAIL reset_comb: strobes=%b ins_data=%h expected 000/0", {info_ready, ins_en, pop_en}, ins_data);
        end
        @(posedge clk); #1;
        tests++;
        if (out_valid !== 1'b0 || out_data !== 32'h0 || bypass_cnt !== 32'h0 || pop_cnt !== 32'h0) begin
            errors++; $display("FAIL reset_regs: v=%b d=%h bc=%0d pc=%0d expected all 0", out_valid, out_data, bypass_cnt, pop_cnt);
        end
        @(negedge clk);
        rstn = 1'b1; info = '0; top = '0;
    endtask

    task automatic test_bypass();
        logic [18:0] ranks [3];
        ranks = '{19'd5, 19'd3, 19'd9};
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            info = mk(1'b1, ranks[i], 12'(i + 1)); top = '0; out_ready = 1'b1; cal_full = 1'b0;
            #1;
            tests++;
            if ({info_ready, ins_en, pop_en} !== 3'b100) begin
                errors++; $display("FAIL bypass_strobes[%0d]: rdy/ins/pop=%b expected 100", i, {info_ready, ins_en, pop_en});
            end
            @(posedge clk); #1;
            tests++;
            if (out_valid !== 1'b1 || out_data !== mk(1'b1, ranks[i], 12'(i + 1))) begin
                errors++; $display("FAIL bypass_out[%0d]: v=%b d=%h expected 1/%h", i, out_valid, out_data, mk(1'b1, ranks[i], 12'(i + 1)));
            end
        end
        @(negedge clk); info = '0;
        @(posedge clk); #1;
        tests++;
        if (bypass_cnt !== 32'd3 || pop_cnt !== 32'd0 || out_valid !== 1'b0) begin
            errors++; $display("FAIL bypass_stats: bc=%0d pc=%0d v=%b expected 3/0/0", bypass_cnt, pop_cnt, out_valid);
        end
    endtask

    task automatic test_equal_rank_pop_wait();
        @(negedge clk);
        top = mk(1'b1, 19'd10, 12'hA); info = mk(1'b1, 19'd10, 12'hB); out_ready = 1'b1;
        #1;
        tests++;
        if ({info_ready, ins_en, pop_en} !== 3'b111 || ins_data !== mk(1'b1, 19'd10, 12'hB)) begin
            errors++; $display("FAIL eq_rank_strobes: rdy/ins/pop=%b ins=%h expected 111/%h", {info_ready, ins_en, pop_en}, ins_data, mk(1'b1, 19'd10, 12'hB));
        end
        @(posedge clk); #1;
        tests++;
        if (out_valid !== 1'b1 || out_data !== mk(1'b1, 19'd10, 12'hA) || pop_cnt !== 32'd1) begin
            errors++; $display("FAIL eq_rank_out: v=%b d=%h pc=%0d expected 1/%h/1", out_valid, out_data, pop_cnt, mk(1'b1, 19'd10, 12'hA));
        end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            info = mk(1'b1, 19'd4, 12'hC);
            #1;
            tests++;
            if ({info_ready, ins_en, pop_en} !== 3'b110) begin
                errors++; $display("FAIL pop_wait_insert[%0d]: rdy/ins/pop=%b expected 110", i, {info_ready, ins_en, pop_en});
            end
            @(posedge clk); #1;
            tests++;
            if (out_valid !== 1'b0) begin
                errors++; $display("FAIL pop_wait_out[%0d]: v=%b expected 0", i, out_valid);
            end
        end
        @(negedge clk); #1;
        tests++;
        if ({info_ready, ins_en, pop_en} !== 3'b100) begin
            errors++; $display("FAIL after_wait_bypass: rdy/ins/pop=%b expected 100", {info_ready, ins_en, pop_en});
        end
        @(posedge clk); #1;
        tests++;
        if (out_valid !== 1'b1 || out_data !== mk(1'b1, 19'd4, 12'hC) || bypass_cnt !== 32'd4) begin
            errors++; $display("FAIL after_wait_out: v=%b d=%h bc=%0d expected 1/%h/4", out_valid, out_data, bypass_cnt, mk(1'b1, 19'd4, 12'hC));
        end
    endtask

    task automatic test_stall();
        @(negedge clk);
        top = '0; info = mk(1'b1, 19'd7, 12'h7); out_ready = 1'b1; cal_full = 1'b0;
        @(posedge clk);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            out_ready = 1'b0; cal_full = 1'b1; info = mk(1'b1, 19'd2, 12'h2); top = mk(1'b1, 19'd1, 12'h1);
            #1;
            tests++;
            if ({info_ready, ins_en, pop_en} !== 3'b000) begin
                errors++; $display("FAIL stall_strobes[%0d]: rdy/ins/pop=%b expected 000", i, {info_ready, ins_en, pop_en});
            end
            @(posedge clk); #1;
            tests++;
            if (out_valid !== 1'b1 || out_data !== mk(1'b1, 19'd7, 12'h7)) begin
                errors++; $display("FAIL stall_hold[%0d]: v=%b d=%h expected 1/%h", i, out_valid, out_data, mk(1'b1, 19'd7, 12'h7));
            end
        end
        @(negedge clk);
        out_ready = 1'b1; cal_full = 1'b0; info = '0; top = '0;
        @(posedge clk); #1;
        tests++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL stall_release: v=%b expected 0", out_valid);
        end
    endtask

    task automatic test_starve();
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            top = mk(1'b1, 19'd100, 12'h64); info = mk(1'b1, 19'd1, 12'h11); out_ready = 1'b1; cal_full = 1'b0;
            #1;
            tests++;
            if ({info_ready, ins_en, pop_en} !== 3'b100) begin
                errors++; $display("FAIL starve_bypass[%0d]: rdy/ins/pop=%b expected 100", i, {info_ready, ins_en, pop_en});
            end
            @(posedge clk);
        end
        @(negedge clk); #1;
`ifdef ROOT_SCHED_STARVE_GUARD_EN
        tests++;
        if ({info_ready, ins_en, pop_en} !== 3'b111) begin
            errors++; $display("FAIL starve_force: rdy/ins/pop=%b expected 111", {info_ready, ins_en, pop_en});
        end
        @(posedge clk); #1;
        tests++;
        if (out_data !== mk(1'b1, 19'd100, 12'h64)) begin
            errors++; $display("FAIL starve_force_out: d=%h expected %h", out_data, mk(1'b1, 19'd100, 12'h64));
        end
`else
        tests++;
        if ({info_ready, ins_en, pop_en} !== 3'b100) begin
            errors++; $display("FAIL starve_noguard: rdy/ins/pop=%b expected 100", {info_ready, ins_en, pop_en});
        end
        @(posedge clk); #1;
        tests++;
        if (out_data !== mk(1'b1, 19'd1, 12'h11)) begin
            errors++; $display("FAIL starve_noguard_out: d=%h expected %h", out_data, mk(1'b1, 19'd1, 12'h11));
        end
`endif
        @(negedge clk); info = '0; top = '0;
        repeat (3) @(posedge clk);
    endtask

    task automatic test_reset_mid_pop_wait();
        @(negedge clk);
        top = mk(1'b1, 19'd50, 12'h32); info = '0; out_ready = 1'b1;
        #1;
        tests++;
        if (pop_en !== 1'b1) begin
            errors++; $display("FAIL midrst_pop: pop=%b expected 1", pop_en);
        end
        @(posedge clk); #1;
        @(negedge clk);
        out_ready = 1'b0; info = mk(1'b1, 19'd3, 12'h3); rstn = 1'b0;
        #1;
        tests++;
        if ({info_ready, ins_en, pop_en} !== 3'b000) begin
            errors++; $display("FAIL midrst_comb: rdy/ins/pop=%b expected 000", {info_ready, ins_en, pop_en});
        end
        @(posedge clk); #1;
        tests++;
        if (out_valid !== 1'b0 || out_data !== 32'h0 || bypass_cnt !== 32'h0 || pop_cnt !== 32'h0) begin
            errors++; $display("FAIL midrst_regs: v=%b d=%h bc=%0d pc=%0d expected all 0", out_valid, out_data, bypass_cnt, pop_cnt);
        end
        @(negedge clk);
        rstn = 1'b1; out_ready = 1'b1; info = '0;
        #1;
        tests++;
        if (pop_en !== 1'b1) begin
            errors++; $display("FAIL midrst_idle: pop=%b expected 1 (state IDLE)", pop_en);
        end
        @(posedge clk); #1;
        tests++;
        if (out_data !== mk(1'b1, 19'd50, 12'h32) || pop_cnt !== 32'd1) begin
            errors++; $display("FAIL midrst_after: d=%h pc=%0d expected %h/1", out_data, pop_cnt, mk(1'b1, 19'd50, 12'h32));
        end
    endtask

    initial begin
        test_reset();
        test_bypass();
        test_equal_rank_pop_wait();
        test_stall();
        test_starve();
        test_reset_mid_pop_wait();
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
